// File: rtl/score_bcd_converter_pkg.sv
// rtl/score_bcd_converter_pkg.sv - shared digit constants and decimal helper for the score converter
package score_bcd_converter_pkg;

  localparam int DIGIT_W      = 4;
  localparam int SCORE_DIGITS = 8;

  // 10^n as a 64-bit constant, used to derive the clamp ceiling at elaboration
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_bcd_converter_bcd_digit_adj.sv
// rtl/score_bcd_converter_bcd_digit_adj.sv - double-dabble digit correction (add 3 when digit >= 5)
module bcd_digit_adj
  import score_bcd_converter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  // a digit of 5 or more would carry wrongly after the shift, so pre-bias it by 3
  assign digit_out = (digit_in >= DIGIT_W'(5)) ? digit_in + DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/score_bcd_converter.sv
// rtl/score_bcd_converter.sv - clamped binary-to-packed-BCD score converter (double dabble, one bit per cycle)
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int N_DIGITS = SCORE_DIGITS,
  parameter int BIN_W    = 32
)
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BIN_W-1:0]            bin_in,
  input  logic                        bin_valid,
  output logic                        bin_ready,
  output logic [DIGIT_W*N_DIGITS-1:0] bcd_out,
  output logic                        bcd_valid,
  output logic                        overflow
);

  localparam int          SW    = DIGIT_W * N_DIGITS;
  localparam int          CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX64 = pow10(N_DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_reg;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    scratch_adj;
  logic             ovf_flag;

  logic             over_max;
  logic [BIN_W-1:0] clamped;

  // clamp keeps every scratch digit at or below 9 for the whole conversion
  assign over_max  = 64'(bin_in) > MAX64;
  assign clamped   = over_max ? MAX64[BIN_W-1:0] : bin_in;
  assign bin_ready = (state == IDLE);

  // one correction cell per digit of the scratch register
  genvar g;
  generate
    for (g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_in  (scratch[g*DIGIT_W +: DIGIT_W]),
        .digit_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // conversion FSM: capture in IDLE, shift BIN_W times in CONV, publish in LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bin_reg   <= '0;
      scratch   <= '0;
      ovf_flag  <= 1'b0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bin_valid) begin
            bin_reg  <= clamped;
            ovf_flag <= over_max;
            scratch  <= '0;
            cnt      <= '0;
            state    <= CONV;
          end
        end
        CONV: begin
          scratch <= {scratch_adj[SW-2:0], bin_reg[BIN_W-1]};
          bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          bcd_out   <= scratch;
          overflow  <= ovf_flag;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// tb/tb_score_bcd_converter.sv - scoreboard bench for score_bcd_converter
module tb_score_bcd_converter;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] bin_in;
  logic        bin_valid;
  logic        bin_ready;
  logic [31:0] bcd_out;
  logic        bcd_valid;
  logic        overflow;

  int          checks;
  int          errors;
  int          cyc;
  exp_t        sb[$];
  logic [31:0] tb_exp_bcd;
  logic        tb_exp_ovf;
  logic [31:0] last_bcd;
  logic        last_ovf;

  score_bcd_converter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // reference: clamp to 99_999_999 then split into decimal digits
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] x;
    logic [31:0] r;
    x = (v > 32'd99999999) ? 32'd99999999 : v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // edge counter and transfer capture
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst_n && bin_valid && bin_ready) begin
      e.bcd = tb_exp_bcd;
      e.ovf = tb_exp_ovf;
      e.due = cyc + 33;
      sb.push_back(e);
    end
  end

  // monitor: pops on every bcd_valid, watches for unexpected output changes
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check32("reset_bcd", bcd_out, 32'h0);
      check32("reset_flags", {29'd0, bin_ready, bcd_valid, overflow}, 32'h4);
      last_bcd = '0;
      last_ovf = 1'b0;
    end else if (bcd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid bcd=%h", bcd_out);
      end else begin
        e = sb.pop_front();
        check32("bcd_out", bcd_out, e.bcd);
        check32("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check32("latency_edge", cyc, e.due);
      end
      last_bcd = bcd_out;
      last_ovf = overflow;
    end else if (bcd_out !== last_bcd || overflow !== last_ovf) begin
      checks++;
      errors++;
      $display("FAIL output_hold actual=%h/%b expected=%h/%b", bcd_out, overflow, last_bcd, last_ovf);
    end
  end

  // waits for a transfer with valid already high; returns its edge number
  task automatic wait_xfer(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      if (bin_ready) begin
        @(posedge clk);
        #1;
        t = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL xfer_timeout actual=no_ready required=ready");
  endtask

  task automatic send(input logic [31:0] v, input logic [31:0] eb, input logic eo);
    int t;
    @(negedge clk);
    bin_in     = v;
    tb_exp_bcd = eb;
    tb_exp_ovf = eo;
    bin_valid  = 1'b1;
    wait_xfer(t);
    @(negedge clk);
    bin_valid = 1'b0;
  endtask

  initial begin
    int t1;
    int t2;
    logic [31:0] r;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    bin_in     = '0;
    bin_valid  = 1'b0;
    tb_exp_bcd = '0;
    tb_exp_ovf = 1'b0;
    last_bcd   = '0;
    last_ovf   = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    send(32'd0,          32'h00000000, 1'b0);
    send(32'd1234,       32'h00001234, 1'b0);
    send(32'd99999999,   32'h99999999, 1'b0);
    send(32'd100000000,  32'h99999999, 1'b1);
    send(32'hFFFFFFFF,   32'h99999999, 1'b1);
    send(32'd5,          32'h00000005, 1'b0);
    send(32'd10,         32'h00000010, 1'b0);
    send(32'd98765432,   32'h98765432, 1'b0);

    // valid held high back to back; bin_in swapped mid-conversion
    @(negedge clk);
    bin_in     = 32'd42;
    tb_exp_bcd = 32'h00000042;
    tb_exp_ovf = 1'b0;
    bin_valid  = 1'b1;
    wait_xfer(t1);
    @(negedge clk);
    bin_in     = 32'd77;
    tb_exp_bcd = 32'h00000077;
    wait_xfer(t2);
    @(negedge clk);
    bin_valid = 1'b0;
    check32("xfer_spacing", 32'(t2 - t1), 32'd34);
    repeat (40) @(negedge clk);

    // reset in the middle of a conversion
    @(negedge clk);
    bin_in     = 32'd1234;
    tb_exp_bcd = 32'h00001234;
    tb_exp_ovf = 1'b0;
    bin_valid  = 1'b1;
    wait_xfer(t1);
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check32("async_reset_bcd", bcd_out, 32'h0);
    check32("async_reset_flags", {29'd0, bin_ready, bcd_valid, overflow}, 32'h4);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send(32'd56, 32'h00000056, 1'b0);

    // random sweep against the decimal reference
    for (int i = 0; i < 200; i++) begin
      case (i % 3)
        0:       r = $urandom;
        1:       r = $urandom_range(0, 99999999);
        default: r = $urandom_range(0, 9999);
      endcase
      send(r, ref_bcd(r), (r > 32'd99999999));
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
